// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions.
// Op encodings, default latencies and FSM state type.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational 64-bit mult/div datapath.
// Res = {hi, lo}; DivZero flags a divide by zero.
module muldiv_arith
    import muldiv_pkg::*;
(
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] Res,
    output logic        DivZero
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // One shared multiplier and one shared magnitude divider
    always_comb begin
        sgn   = (Op == MD_MULT) || (Op == MD_DIV);
        ext_a = sgn ? {{32{A[31]}}, A} : {32'b0, A};
        ext_b = sgn ? {{32{B[31]}}, B} : {32'b0, B};
        prod  = ext_a * ext_b;

        mag_a = (sgn && A[31]) ? (32'd0 - A) : A;
        mag_b = (sgn && B[31]) ? (32'd0 - B) : B;
        dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q     = mag_a / dvs;
        r     = mag_a % dvs;
        q_s   = (sgn && (A[31] ^ B[31])) ? (32'd0 - q) : q;
        r_s   = (sgn && A[31]) ? (32'd0 - r) : r;

        DivZero = Op[1] && (B == 32'd0);
        Res     = Op[1] ? {r_s, q_s} : prod;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller.
// Fixed-latency busy window, commit at the last busy edge.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MtHi,
    input  logic        MtLo,
    input  logic [31:0] WData,
    input  logic        Flush,
    input  logic        DMulDiv,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    localparam int MAXC = max_int(MULT_CYCLES, DIV_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          pdz_q, pdz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic [63:0]   res;
    logic          div_zero;

    muldiv_arith u_arith (
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Res     (res),
        .DivZero (div_zero)
    );

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            pdz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pdz_q   <= pdz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next state: issue/mt in IDLE, count down or abort in BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pdz_d   = pdz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (!Flush) begin
                    if (Start) begin
                        pend_d  = res;
                        pdz_d   = div_zero;
                        cnt_d   = Op[1] ? DIV_N : MULT_N;
                        state_d = ST_BUSY;
                    end else begin
                        if (MtHi) hi_d = WData;
                        if (MtLo) lo_d = WData;
                    end
                end
            end
            ST_BUSY: begin
                if (Flush) begin
                    pend_d  = '0;
                    pdz_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == ONE) begin
                    if (!pdz_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Busy  = (state_q == ST_BUSY);
    assign Stall = DMulDiv & (Start | Busy);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl.
// Directed literal cases plus randomized traffic vs a reference model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        MtHi = 1'b0;
    logic        MtLo = 1'b0;
    logic [31:0] WData = '0;
    logic        Flush = 1'b0;
    logic        DMulDiv = 1'b0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Stall;

    int tests = 0;
    int fails = 0;

    muldiv_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .MtHi    (MtHi),
        .MtLo    (MtLo),
        .WData   (WData),
        .Flush   (Flush),
        .DMulDiv (DMulDiv),
        .HI      (HI),
        .LO      (LO),
        .Busy    (Busy),
        .Stall   (Stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: remaining busy cycles and the result to commit
    int          m_rem = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;
    bit          m_dz = 1'b0;

    function automatic void ref_op(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [63:0] res,
                                   output bit dz);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        res = '0;
        case (op)
            2'd0: res = 64'(sa * sb);
            2'd1: res = ua * ub;
            2'd2: if (b == 0) dz = 1'b1;
                  else res = {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 0) dz = 1'b1;
                  else res = {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0;
            m_hi  = '0;
            m_lo  = '0;
        end else if (m_rem > 0) begin
            if (Flush) m_rem = 0;
            else if (m_rem == 1) begin
                if (!m_dz) {m_hi, m_lo} = m_res;
                m_rem = 0;
            end else m_rem = m_rem - 1;
        end else if (!Flush) begin
            if (Start) begin
                ref_op(Op, A, B, m_res, m_dz);
                m_rem = Op[1] ? 10 : 5;
            end else begin
                if (MtHi) m_hi = WData;
                if (MtLo) m_lo = WData;
            end
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        chk("hi", 64'(HI), 64'(m_hi));
        chk("lo", 64'(LO), 64'(m_lo));
        chk("busy", 64'(Busy), 64'(m_rem > 0));
        chk("stall", 64'(Stall), 64'(DMulDiv & (Start | (m_rem > 0))));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        cyc();
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        cyc();
        Start = 1'b0;
    endtask

    task automatic busy_len(output int n, output int st);
        n = 0;
        st = 0;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            n++;
            st += int'(Stall);
            cyc();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, st;
        #2 reset = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        reset = 1'b0;

        issue(2'b00, 32'hFFFF_FFFF, 32'd2);
        busy_len(n, st);
        chk("mult_len", 64'(n), 64'd5);
        chk("mult_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);

        issue(2'b01, 32'hFFFF_FFFF, 32'd2);
        busy_len(n, st);
        chk("multu_len", 64'(n), 64'd5);
        chk("multu_res", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

        cyc();
        DMulDiv = 1'b1;
        Start = 1'b1;
        Op = 2'b10;
        A = -32'sd7;
        B = 32'd2;
        #1;
        chk("div_stall0", 64'(Stall), 64'd1);
        st = int'(Stall);
        cyc();
        Start = 1'b0;
        begin
            int s2;
            busy_len(n, s2);
            st += s2;
        end
        chk("div_len", 64'(n), 64'd10);
        chk("div_stall", 64'(st), 64'd11);
        chk("div_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("stall_idle", 64'(Stall), 64'd0);
        DMulDiv = 1'b0;

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n, st);
        chk("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

        cyc();
        MtHi = 1'b1;
        MtLo = 1'b1;
        WData = 32'h11;
        cyc();
        MtLo = 1'b0;
        WData = 32'h22;
        MtHi = 1'b0;
        MtLo = 1'b1;
        cyc();
        MtLo = 1'b0;
        chk("mt_pre", {HI, LO}, 64'h0000_0011_0000_0022);
        issue(2'b11, 32'd5, 32'd0);
        busy_len(n, st);
        chk("divz_len", 64'(n), 64'd10);
        chk("divz_res", {HI, LO}, 64'h0000_0011_0000_0022);

        issue(2'b00, 32'd3, 32'd4);
        cyc();
        Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        for (int i = 0; i < 8; i++) cyc();
        chk("flush_hilo", {HI, LO}, 64'h0000_0011_0000_0022);
        MtHi = 1'b1;
        WData = 32'hABCD;
        cyc();
        MtHi = 1'b0;
        chk("mthi", 64'(HI), 64'hABCD);

        issue(2'b10, 32'd100, 32'd7);
        cyc();
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_hilo", {HI, LO}, 64'd0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) cyc();
        chk("arst_after", {HI, LO, 31'd0, Busy}, 96'd0);

        for (int i = 0; i < 1500; i++) begin
            cyc();
            Start   = ($urandom_range(0, 3) == 0);
            Op      = 2'($urandom);
            A       = pick();
            B       = pick();
            MtHi    = ($urandom_range(0, 3) == 0);
            MtLo    = ($urandom_range(0, 3) == 0);
            WData   = $urandom;
            Flush   = ($urandom_range(0, 15) == 0);
            DMulDiv = 1'($urandom);
            reset   = ($urandom_range(0, 199) == 0);
        end
        cyc();
        Start = 1'b0;
        MtHi = 1'b0;
        MtLo = 1'b0;
        Flush = 1'b0;
        reset = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
